// File: rtl/vco_sar_calibrator.sv
// SAR calibration controller for the PLL VCO: restarts the VCO per trial and counts its edges over a window.
// Optional lock verification trial is built when VCO_CAL_LOCK_CHECK_EN is defined.
module vco_sar_calibrator #(
  parameter int unsigned CTRL_W = 10,
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned WINDOW = 256,
  parameter int unsigned SETTLE = 16
`ifdef VCO_CAL_LOCK_CHECK_EN
  , parameter int unsigned LOCK_TOL = 2
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  target_count,
  input  logic              vco_clock_in,
  output logic [CTRL_W-1:0] vco_ctrl,
  output logic              vco_reset,
  output logic [CTRL_W-1:0] cal_code,
  output logic [CNT_W-1:0]  last_count,
  output logic              busy,
  output logic              done,
  output logic              locked
);

  localparam int unsigned T_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int unsigned TMR_W = $clog2(T_MAX + 1);
  localparam int unsigned IDX_W = (CTRL_W > 1) ? $clog2(CTRL_W) : 1;
  localparam logic [TMR_W-1:0] WIN_LD = TMR_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] SET_LD = TMR_W'((SETTLE == 0) ? 0 : SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESTART, S_SETTLE, S_MEASURE, S_DECIDE, S_DONE
  } state_t;

  state_t             r_state, w_state_nxt, w_meas_exit, w_final_exit;
  logic [CTRL_W-1:0]  r_trial, r_cal_code, w_trial_dec;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_target, r_count, r_last_count, w_count_nxt;
  logic [TMR_W-1:0]   r_timer;
  logic               r_prev, w_edge, w_last_bit, w_abort;

  assign w_edge      = vco_clock_in & ~r_prev;
  assign w_count_nxt = (r_count == '1) ? r_count : r_count + CNT_W'(w_edge);
  assign w_trial_dec = (r_count > r_target) ? (r_trial & ~(CTRL_W'(1) << r_idx)) : r_trial;
  assign w_last_bit  = (r_idx == '0);
  assign w_abort     = abort && (r_state != S_DONE);

`ifdef VCO_CAL_LOCK_CHECK_EN
  logic r_verify, r_locked;
  // The final SAR decision loops back for one verification trial at the committed code.
  assign w_meas_exit  = r_verify ? S_DONE : S_DECIDE;
  assign w_final_exit = S_RESTART;
  assign locked       = r_locked;
`else
  assign w_meas_exit  = S_DECIDE;
  assign w_final_exit = S_DONE;
  assign locked       = done;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_RESTART;
      S_RESTART: w_state_nxt = (SETTLE == 0) ? S_MEASURE : S_SETTLE;
      S_SETTLE:  if (r_timer == '0) w_state_nxt = S_MEASURE;
      S_MEASURE: if (r_timer == '0) w_state_nxt = w_meas_exit;
      S_DECIDE:  w_state_nxt = w_last_bit ? w_final_exit : S_RESTART;
      S_DONE:    if (start) w_state_nxt = S_RESTART;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_trial      <= '0;
      r_cal_code   <= '0;
      r_idx        <= '0;
      r_target     <= '0;
      r_count      <= '0;
      r_last_count <= '0;
      r_timer      <= '0;
      r_prev       <= 1'b0;
`ifdef VCO_CAL_LOCK_CHECK_EN
      r_verify     <= 1'b0;
      r_locked     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= vco_clock_in;
      if (!w_abort) begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (w_state_nxt == S_RESTART) begin
              r_target <= target_count;
              r_idx    <= IDX_W'(CTRL_W - 1);
              r_trial  <= CTRL_W'(1) << (CTRL_W - 1);
`ifdef VCO_CAL_LOCK_CHECK_EN
              r_verify <= 1'b0;
              r_locked <= 1'b0;
`endif
            end
          end
          S_RESTART: begin
            r_count <= '0;
            r_timer <= (SETTLE == 0) ? WIN_LD : SET_LD;
          end
          S_SETTLE: r_timer <= (r_timer == '0) ? WIN_LD : r_timer - TMR_W'(1);
          S_MEASURE: begin
            r_count <= w_count_nxt;
            if (r_timer != '0) r_timer <= r_timer - TMR_W'(1);
`ifdef VCO_CAL_LOCK_CHECK_EN
            if (r_timer == '0 && r_verify) begin
              r_last_count <= w_count_nxt;
              r_locked     <= (w_count_nxt <= r_target) &&
                              ((r_target - w_count_nxt) <= CNT_W'(LOCK_TOL));
            end
`endif
          end
          S_DECIDE: begin
            r_last_count <= r_count;
            if (!w_last_bit) begin
              r_trial <= w_trial_dec | (CTRL_W'(1) << (r_idx - IDX_W'(1)));
              r_idx   <= r_idx - IDX_W'(1);
            end else begin
              r_trial    <= w_trial_dec;
              r_cal_code <= w_trial_dec;
`ifdef VCO_CAL_LOCK_CHECK_EN
              r_verify   <= 1'b1;
`endif
            end
          end
          default: ;
        endcase
      end
`ifdef VCO_CAL_LOCK_CHECK_EN
      if (abort) r_locked <= 1'b0;
`endif
    end
  end

  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done       = (r_state == S_DONE);
  assign vco_reset  = reset | (r_state == S_RESTART);
  assign vco_ctrl   = busy ? r_trial : r_cal_code;
  assign cal_code   = r_cal_code;
  assign last_count = r_last_count;

endmodule

// File: tb/tb_vco_sar_calibrator.sv
// Scoreboard bench for vco_sar_calibrator: expected results queued at start, checked when done rises.
// A second small instance exercises counter saturation and the zero-settle path.
module tb_vco_sar_calibrator;

  localparam int CTRL_W = 10;
`ifdef VCO_CAL_LOCK_CHECK_EN
  localparam int LAT = 3013, LAT2 = 329, LCK_4095 = 0;
`else
  localparam int LAT = 2740, LAT2 = 264, LCK_4095 = 1;
`endif

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, vco_clock_in = 1'b0;
  logic [11:0] target_count = '0;
  logic [9:0]  vco_ctrl, cal_code;
  logic [11:0] last_count;
  logic        vco_reset, busy, done, locked;

  logic        start2 = 1'b0, vclk2 = 1'b0;
  logic [3:0]  target2 = 4'd15;
  logic [3:0]  vco_ctrl2, cal_code2, last_count2;
  logic        vco_reset2, busy2, done2, locked2;

  vco_sar_calibrator dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .target_count(target_count),
    .vco_clock_in(vco_clock_in), .vco_ctrl(vco_ctrl), .vco_reset(vco_reset), .cal_code(cal_code),
    .last_count(last_count), .busy(busy), .done(done), .locked(locked)
  );

  vco_sar_calibrator #(.CTRL_W(4), .CNT_W(4), .WINDOW(64), .SETTLE(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(1'b0), .target_count(target2),
    .vco_clock_in(vclk2), .vco_ctrl(vco_ctrl2), .vco_reset(vco_reset2), .cal_code(cal_code2),
    .last_count(last_count2), .busy(busy2), .done(done2), .locked(locked2)
  );

  typedef struct { int cal; int cnt; int lat; int lck; } exp_t;
  exp_t exp_q[$];
  exp_t exp2_q[$];
  int   trial_q[$];
  int   n_checks = 0, n_errors = 0, cyc = 0, t_start = 0, t_start2 = 0;
  logic fail_verify = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // VCO model: after restart, n rising edges placed inside the measure window (clk-sampled, so n<=128).
  function automatic int edges_for(input int code);
    int n;
    n = code >> 2;
    return (n > 128) ? 128 : n;
  endfunction

  int   k = 0, tcnt = 0;
  logic prev_vr_m = 1'b0;
  always @(negedge clk) begin : vco_model
    int n;
    if (!busy) tcnt = 0;
    else if (vco_reset && !prev_vr_m) tcnt = tcnt + 1;
    prev_vr_m = vco_reset;
    n = (fail_verify && tcnt == CTRL_W + 1) ? int'(target_count) + 3 : edges_for(int'(vco_ctrl));
    if (vco_reset) begin
      k = 0;
      vco_clock_in = 1'b0;
    end else begin
      k = k + 1;
      vco_clock_in = (k >= 17) && ((k - 16) < 2 * n) && (((k - 16) % 2) == 1);
    end
    vclk2 = ~vclk2;
  end

  logic m_prev_done = 1'b0, m_prev_vr = 1'b0, m_prev_busy = 1'b0, m_prev_done2 = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (vco_reset && busy && !m_prev_vr && trial_q.size() > 0)
      check("trial_ctrl", int'(vco_ctrl), trial_q.pop_front());
    if (m_prev_vr && m_prev_busy)
      check("vco_reset_width", int'(vco_reset), 0);
    if (done && !m_prev_done) begin
      if (exp_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("cal_code", int'(cal_code), e.cal);
        check("last_count", int'(last_count), e.cnt);
        check("done_latency", cyc - t_start, e.lat);
        check("locked", int'(locked), e.lck);
        check("trials_seen", trial_q.size(), 0);
      end
    end
    if (done2 && !m_prev_done2) begin
      if (exp2_q.size() == 0) check("unexpected_done2", 1, 0);
      else begin
        e = exp2_q.pop_front();
        check("sat_cal_code", int'(cal_code2), e.cal);
        check("sat_last_count", int'(last_count2), e.cnt);
        check("sat_latency", cyc - t_start2, e.lat);
        check("sat_locked", int'(locked2), e.lck);
      end
    end
    m_prev_done  = done;
    m_prev_vr    = vco_reset;
    m_prev_busy  = busy;
    m_prev_done2 = done2;
  end

  task automatic pulse_start(input int tgt);
    @(negedge clk);
    target_count = 12'(tgt);
    start = 1'b1;
    t_start = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while (!done && i < limit) begin
      @(negedge clk);
      i++;
    end
    check("done_seen", int'(done), 1);
    @(negedge clk);
  endtask

  task automatic push_run(input int t0, t1, t2, t3, t4, t5, t6, t7, t8, t9,
                          input int cal, cnt, lck);
    int tv[10];
    tv = '{t0, t1, t2, t3, t4, t5, t6, t7, t8, t9};
    foreach (tv[i]) trial_q.push_back(tv[i]);
`ifdef VCO_CAL_LOCK_CHECK_EN
    trial_q.push_back(cal);
`endif
    exp_q.push_back('{cal: cal, cnt: cnt, lat: LAT, lck: lck});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_vco_ctrl"}, int'(vco_ctrl), 0);
    check({tag, "_vco_reset"}, int'(vco_reset), 1);
    check({tag, "_cal_code"}, int'(cal_code), 0);
    check({tag, "_last_count"}, int'(last_count), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_locked"}, int'(locked), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    check("idle_vco_reset", int'(vco_reset), 0);
    check("idle_busy", int'(busy), 0);

    // asynchronous reset in the middle of the first measure window
    pulse_start(100);
    repeat (100) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_vco_reset", int'(vco_reset), 0);
    check("post_rst_busy", int'(busy), 0);

    // saturating counter on the small instance
    exp2_q.push_back('{cal: 15, cnt: 15, lat: LAT2, lck: 1});
    @(negedge clk);
    start2 = 1'b1;
    t_start2 = cyc + 1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 600 && !done2; i++) @(negedge clk);
    check("done2_seen", int'(done2), 1);
    @(negedge clk);

    // target=100, with a start held while busy
    push_run(512, 256, 384, 448, 416, 400, 408, 404, 402, 403, 403, 100, 1);
    pulse_start(100);
    repeat (500) @(negedge clk);
    start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_done(4000);

    // abort 1000 cycles into a run, then abort+start together in IDLE
    pulse_start(0);
    repeat (999) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_cal_code", int'(cal_code), 403);
    check("abort_vco_ctrl", int'(vco_ctrl), 403);
    check("abort_done", int'(done), 0);
    check("abort_locked", int'(locked), 0);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_start_busy", int'(busy), 0);

    push_run(512, 256, 128, 64, 32, 16, 8, 4, 2, 3, 3, 0, 1);
    pulse_start(0);
    wait_done(4000);

    push_run(512, 768, 896, 960, 992, 1008, 1016, 1020, 1022, 1023, 1023, 128, LCK_4095);
    pulse_start(4095);
    wait_done(4000);

`ifdef VCO_CAL_LOCK_CHECK_EN
    trial_q.delete();
    push_run(512, 256, 384, 448, 416, 400, 408, 404, 402, 403, 403, 103, 0);
    fail_verify = 1'b1;
    pulse_start(100);
    wait_done(4000);
    fail_verify = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp2_q_drained", exp2_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
